button_debounce_combo: RTL and testbench

- Parametrised multi-channel pushbutton front end for the Pmod buttons.
- Each active-low button input is synchronised, debounced with a per-channel counter and edge-detected.
- Produces per-channel debounced level, press/release/long-hold pulses and a toggle latch, plus an all-buttons combo level and pulse.
- Sits between the raw pmod pins and LED or application logic. Replaces ad-hoc combinational button gating.

---
 rtl/button_debounce_combo.sv | 81 ++++++++
 tb/tb_button_debounce_combo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_combo.sv
// button_debounce_combo: synchronise, debounce and edge-detect active-low pushbuttons,
// with per-channel press/release/hold pulses, toggle latch and an all-buttons combo.
module button_debounce_combo #(
    parameter int NUM_BTNS        = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 12000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] pmod,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_hold,
    output logic [NUM_BTNS-1:0] btn_toggle,
    output logic                combo,
    output logic                combo_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(HOLD_CYCLES - 2);

    logic [NUM_BTNS-1:0] sync1, sync2, state_next, hold_fire, rise;
    logic [CW-1:0] cnt [NUM_BTNS];
    logic [CW-1:0] cnt_next [NUM_BTNS];
    logic [HW-1:0] hold_cnt [NUM_BTNS];
    logic [HW-1:0] hold_next [NUM_BTNS];

    // hold counter saturates at HOLD_LAST so the pulse fires once per press
    always_comb begin
        state_next = btn_state;
        hold_fire  = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_next[i]  = '0;
            hold_next[i] = '0;
            if (~sync2[i] != btn_state[i]) begin
                if (cnt[i] == DB_LAST) state_next[i] = ~sync2[i];
                else cnt_next[i] = cnt[i] + CW'(1);
            end
            if (btn_state[i]) begin
                hold_next[i] = (hold_cnt[i] == HOLD_LAST) ? hold_cnt[i] : hold_cnt[i] + HW'(1);
                hold_fire[i] = hold_cnt[i] == HOLD_FIRE;
            end
        end
        rise = state_next & ~btn_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '1;
            sync2       <= '1;
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_hold    <= '0;
            btn_toggle  <= '0;
            combo       <= 1'b0;
            combo_press <= 1'b0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt[i]      <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync1       <= pmod;
            sync2       <= sync1;
            btn_state   <= state_next;
            btn_press   <= rise;
            btn_release <= ~state_next & btn_state;
            btn_hold    <= hold_fire;
            btn_toggle  <= btn_toggle ^ rise;
            combo       <= &state_next;
            combo_press <= (&state_next) & ~combo;
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt[i]      <= cnt_next[i];
                hold_cnt[i] <= hold_next[i];
            end
        end
    end
endmodule

// File: tb/tb_button_debounce_combo.sv
// tb_button_debounce_combo: two configurations checked every cycle against a history-based model.
`timescale 1ns/1ps
module tb_button_debounce_combo;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] pa;
    logic [3:0] pb;
    logic [1:0] a_state, a_press, a_rel, a_hold, a_tog;
    logic [3:0] b_state, b_press, b_rel, b_hold, b_tog;
    logic a_combo, a_cp, b_combo, b_cp;
    int vectors = 0;
    int miscompares = 0;

    logic [7:0] hist [2][8192];
    logic [7:0] m_state [2];
    logic [7:0] m_press [2];
    logic [7:0] m_rel [2];
    logic [7:0] m_hold [2];
    logic [7:0] m_tog [2];
    logic m_combo [2];
    logic m_cp [2];
    int m_n [2];
    int last_flip [2][8];
    int press_edge [2][8];

    always #5 clk = ~clk;

    button_debounce_combo #(.NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .pmod(pa), .btn_state(a_state), .btn_press(a_press),
        .btn_release(a_rel), .btn_hold(a_hold), .btn_toggle(a_tog),
        .combo(a_combo), .combo_press(a_cp));

    button_debounce_combo #(.NUM_BTNS(4), .DEBOUNCE_CYCLES(2), .HOLD_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .pmod(pb), .btn_state(b_state), .btn_press(b_press),
        .btn_release(b_rel), .btn_hold(b_hold), .btn_toggle(b_tog),
        .combo(b_combo), .combo_press(b_cp));

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_state[u] = '0; m_press[u] = '0; m_rel[u] = '0; m_hold[u] = '0; m_tog[u] = '0;
            m_combo[u] = 1'b0; m_cp[u] = 1'b0; m_n[u] = 0;
            for (int i = 0; i < 8; i++) begin
                last_flip[u][i] = -1;
                press_edge[u][i] = -100000;
            end
        end
    endtask

    // A level is accepted once the last d debounce samples since the previous
    // acceptance all disagree with the current level; samples lag the pin by 2 edges.
    task automatic model_step(int u, logic [7:0] pin, int nb, int d, int h);
        logic [7:0] old, nw, mask;
        int n;
        bit ok;
        logic r;
        old = m_state[u];
        nw = old;
        n = m_n[u];
        hist[u][n] = pin;
        mask = 8'((1 << nb) - 1);
        m_hold[u] = '0;
        for (int i = 0; i < nb; i++) begin
            ok = 1'b1;
            for (int j = 0; j < d; j++) begin
                r = (n - j < 2) ? 1'b0 : ~hist[u][n-j-2][i];
                if (n - j <= last_flip[u][i] || r == old[i]) ok = 1'b0;
            end
            if (ok) begin
                nw[i] = ~old[i];
                last_flip[u][i] = n;
            end
            m_hold[u][i] = old[i] && (n - press_edge[u][i] == h - 1);
            if (nw[i] && !old[i]) press_edge[u][i] = n;
        end
        m_press[u] = nw & ~old & mask;
        m_rel[u] = ~nw & old & mask;
        m_tog[u] = m_tog[u] ^ m_press[u];
        m_state[u] = nw;
        m_cp[u] = ((nw | ~mask) == 8'hFF) && !m_combo[u];
        m_combo[u] = (nw | ~mask) == 8'hFF;
        m_n[u] = n + 1;
    endtask

    task automatic check(string tag);
        logic [11:0] ga, ea;
        logic [21:0] gb, eb;
        ga = {a_state, a_press, a_rel, a_hold, a_tog, a_combo, a_cp};
        ea = {m_state[0][1:0], m_press[0][1:0], m_rel[0][1:0], m_hold[0][1:0], m_tog[0][1:0], m_combo[0], m_cp[0]};
        gb = {b_state, b_press, b_rel, b_hold, b_tog, b_combo, b_cp};
        eb = {m_state[1][3:0], m_press[1][3:0], m_rel[1][3:0], m_hold[1][3:0], m_tog[1][3:0], m_combo[1], m_cp[1]};
        vectors++;
        assert (ga === ea) else begin
            miscompares++;
            $error("FAIL %s/a at %0t: got=%h expected=%h", tag, $time, ga, ea);
        end
        vectors++;
        assert (gb === eb) else begin
            miscompares++;
            $error("FAIL %s/b at %0t: got=%h expected=%h", tag, $time, gb, eb);
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0, 8'(pa), 2, 4, 16);
            model_step(1, 8'(pb), 4, 2, 8);
        end
        #1 check(tag);
    endtask

    task automatic run(int n, string tag);
        repeat (n) tick(tag);
    endtask

    task automatic do_areset(string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check(tag);
        run(2, tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pa = '1;
        pb = '1;
        model_reset();
        run(2, "reset");
        @(negedge clk);
        rst = 1'b0;
        run(3, "idle");
        pa = 2'b10;
        run(10, "press0");
        pa = 2'b11;
        run(10, "release0");
        pa = 2'b10;
        run(3, "bounce_short");
        pa = 2'b11;
        run(6, "bounce_short");
        for (int k = 0; k < 20; k++) begin
            pa = (k % 2 == 0) ? 2'b10 : 2'b11;
            run(2, "bounce_alt");
        end
        pa = 2'b11;
        run(6, "bounce_end");
        pa = 2'b10;
        run(35, "hold0");
        pa = 2'b11;
        run(10, "hold_release");
        pa = 2'b10;
        run(10, "press_again");
        pa = 2'b11;
        run(10, "release_again");
        pa = 2'b00;
        pb = 4'b0000;
        run(10, "combo");
        pa = 2'b01;
        pb = 4'b0100;
        run(10, "combo_drop");
        pa = 2'b11;
        pb = 4'b1111;
        run(10, "combo_off");
        pa = 2'b10;
        run(2, "rst_debounce");
        do_areset("rst_debounce");
        run(12, "reaccept");
        run(8, "hold_mid");
        do_areset("rst_hold");
        run(25, "reaccept_hold");
        pa = 2'b11;
        run(10, "post_rst_rel");
        pb = 4'b1110;
        run(6, "walk0");
        pb = 4'b1100;
        run(6, "walk1");
        pb = 4'b1000;
        run(6, "walk2");
        pb = 4'b0000;
        run(12, "walk3");
        pb = 4'b1111;
        run(8, "walk_rel");
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 5) == 0) pa = 2'($urandom);
            if ($urandom_range(0, 5) == 0) pb = 4'($urandom);
            if ($urandom_range(0, 399) == 0) do_areset("rand_rst");
            tick("random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
